// File: rtl/bcd_display_driver_pkg.sv
// Shared seven-segment constants and scan FSM encoding for display blocks.
package bcd_display_driver_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    // Scan FSM: each digit slot is a blanking phase followed by a drive phase.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/bcd_display_driver_seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder.
module seg7_decode
    import bcd_display_driver_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);

    // Codes above 9 never reach the register, but still show a dash if they do.
    always_comb begin
        seg_n = SEG_DASH;
        case (bcd)
            4'd0: seg_n = SEG_0;
            4'd1: seg_n = SEG_1;
            4'd2: seg_n = SEG_2;
            4'd3: seg_n = SEG_3;
            4'd4: seg_n = SEG_4;
            4'd5: seg_n = SEG_5;
            4'd6: seg_n = SEG_6;
            4'd7: seg_n = SEG_7;
            4'd8: seg_n = SEG_8;
            4'd9: seg_n = SEG_9;
            default: seg_n = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_driver.sv
// Calculator-style digit entry register multiplexed onto a common-anode
// seven-segment display with inter-digit blanking and leading blanking.
module bcd_display_driver
    import bcd_display_driver_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int BLANK_CYC  = 50
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [3:0]                          bcd_in,
    input  logic                                bcd_valid,
    input  logic                                clear,
    output logic [6:0]                          seg_n,
    output logic [NUM_DIGITS-1:0]               an_n,
    output logic [$clog2(NUM_DIGITS+1)-1:0]     digit_cnt,
    output logic                                err
);

    localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int SLOT_W = $clog2(SCAN_DIV);

    logic [NUM_DIGITS-1:0][3:0] digit_reg, digit_next;
    logic [CNT_W-1:0]           digit_cnt_reg, digit_cnt_next;
    logic                       err_reg;
    logic                       accept;

    scan_state_t                state_reg, state_next;
    logic [SLOT_W-1:0]          slot_reg, slot_next;
    logic [IDX_W-1:0]           idx_reg, idx_next;

    logic [6:0]                 seg_reg, seg_next, seg_dec;
    logic [NUM_DIGITS-1:0]      an_reg, an_next;
    logic                       lit;

    assign accept = bcd_valid && !clear && (bcd_in <= 4'd9);

    // Shift register: digit 0 takes the new entry, the rest move one place left.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        if (gi == 0) begin : g_first
            assign digit_next[gi] = clear  ? 4'd0 :
                                    accept ? bcd_in : digit_reg[gi];
        end else begin : g_rest
            assign digit_next[gi] = clear  ? 4'd0 :
                                    accept ? digit_reg[gi-1] : digit_reg[gi];
        end
    end

    // Entry count saturates once every position holds a digit.
    always_comb begin
        digit_cnt_next = digit_cnt_reg;
        if (clear)
            digit_cnt_next = '0;
        else if (accept && digit_cnt_reg != CNT_W'(NUM_DIGITS))
            digit_cnt_next = digit_cnt_reg + 1'b1;
    end

    // Digit register, count and reject pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_reg     <= '0;
            digit_cnt_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            digit_reg     <= digit_next;
            digit_cnt_reg <= digit_cnt_next;
            err_reg       <= bcd_valid && !clear && (bcd_in > 4'd9);
        end
    end

    // Scan next-state: slot counter free-runs, index advances after each drive phase.
    always_comb begin
        state_next = state_reg;
        slot_next  = slot_reg + 1'b1;
        idx_next   = idx_reg;
        case (state_reg)
            ST_BLANK: begin
                if (slot_reg == SLOT_W'(BLANK_CYC - 1))
                    state_next = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (slot_reg == SLOT_W'(SCAN_DIV - 1)) begin
                    state_next = ST_BLANK;
                    slot_next  = '0;
                    idx_next   = (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_BLANK;
                slot_next  = '0;
                idx_next   = '0;
            end
        endcase
    end

    seg7_decode u_dec (
        .bcd   (digit_reg[idx_next]),
        .seg_n (seg_dec)
    );

    // Outputs are computed from the next scan position so the registered
    // anode/segment values line up with the FSM state of the same cycle.
    always_comb begin
        lit     = (state_next == ST_DRIVE) && (CNT_W'(idx_next) < digit_cnt_reg);
        an_next = '1;
        seg_next = SEG_OFF;
        if (lit) begin
            an_next  = ~(NUM_DIGITS'(1) << idx_next);
            seg_next = seg_dec;
        end
    end

    // Scan state and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_BLANK;
            slot_reg  <= '0;
            idx_reg   <= '0;
            an_reg    <= '1;
            seg_reg   <= SEG_OFF;
        end else begin
            state_reg <= state_next;
            slot_reg  <= slot_next;
            idx_reg   <= idx_next;
            an_reg    <= an_next;
            seg_reg   <= seg_next;
        end
    end

    assign seg_n     = seg_reg;
    assign an_n      = an_reg;
    assign digit_cnt = digit_cnt_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed bench for bcd_display_driver with a 4-digit, 8-cycle-slot scan.
module tb_bcd_display_driver;

    localparam int NUM_DIGITS = 4;
    localparam int SCAN_DIV   = 8;
    localparam int BLANK_CYC  = 2;

    localparam logic [6:0] P_OFF = 7'h7F;
    localparam logic [6:0] P_1   = 7'b1111001;
    localparam logic [6:0] P_2   = 7'b0100100;
    localparam logic [6:0] P_3   = 7'b0110000;
    localparam logic [6:0] P_4   = 7'b0011001;
    localparam logic [6:0] P_5   = 7'b0010010;
    localparam logic [6:0] P_7   = 7'b1111000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] bcd_in = 4'd0;
    logic       bcd_valid = 1'b0;
    logic       clear = 1'b0;
    logic [6:0] seg_n;
    logic [3:0] an_n;
    logic [2:0] digit_cnt;
    logic       err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_display_driver #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .BLANK_CYC  (BLANK_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bcd_in    (bcd_in),
        .bcd_valid (bcd_valid),
        .clear     (clear),
        .seg_n     (seg_n),
        .an_n      (an_n),
        .digit_cnt (digit_cnt),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic enter(input logic [3:0] d);
        @(negedge clk);
        bcd_in    = d;
        bcd_valid = 1'b1;
        @(negedge clk);
        bcd_valid = 1'b0;
        $display("entry %0d -> digit_cnt %0d err %0b", d, digit_cnt, err);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        $display("clear -> digit_cnt %0d", digit_cnt);
    endtask

    // Watch one full frame plus margin; record the segments seen on each
    // anode and flag any cycle with two anodes on or lit segments while dark.
    task automatic capture(input string tag, input logic [3:0][6:0] exp_seg, input logic [3:0] exp_seen);
        logic [3:0]      seen;
        logic [3:0][6:0] segs;
        logic            bad;
        seen = '0;
        segs = '1;
        bad  = 1'b0;
        repeat (NUM_DIGITS * SCAN_DIV + 4) begin
            @(negedge clk);
            if ($countones(~an_n) > 1) bad = 1'b1;
            if (an_n == 4'hF && seg_n != P_OFF) bad = 1'b1;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (!an_n[k]) begin
                    if (seen[k] && segs[k] != seg_n) bad = 1'b1;
                    seen[k] = 1'b1;
                    segs[k] = seg_n;
                end
            end
        end
        check({tag, " anodes seen"}, 32'(seen), 32'(exp_seen));
        for (int k = 0; k < NUM_DIGITS; k++)
            if (exp_seen[k]) check($sformatf("%s slot%0d seg", tag, k), 32'(segs[k]), 32'(exp_seg[k]));
        check({tag, " glitch"}, 32'(bad), 32'd0);
        $display("frame %s: anodes %b", tag, seen);
    endtask

    initial begin
        logic       dark_bad;
        logic       found;
        logic [3:0][6:0] e;

        // Reset state
        #12;
        check("rst an_n", 32'(an_n), 32'hF);
        check("rst seg_n", 32'(seg_n), 32'(P_OFF));
        check("rst cnt", 32'(digit_cnt), 32'd0);
        check("rst err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle: dark throughout
        dark_bad = 1'b0;
        repeat (64) begin
            @(negedge clk);
            if (an_n != 4'hF || seg_n != P_OFF || digit_cnt != 3'd0) dark_bad = 1'b1;
        end
        check("idle dark", 32'(dark_bad), 32'd0);

        // 1,2,3
        enter(4'd1); enter(4'd2); enter(4'd3);
        check("cnt 123", 32'(digit_cnt), 32'd3);
        e = {P_OFF, P_1, P_2, P_3};
        capture("123", e, 4'b0111);

        // Invalid code
        @(negedge clk);
        bcd_in    = 4'hC;
        bcd_valid = 1'b1;
        check("err before", 32'(err), 32'd0);
        @(negedge clk);
        bcd_valid = 1'b0;
        check("err pulse", 32'(err), 32'd1);
        @(negedge clk);
        check("err drop", 32'(err), 32'd0);
        check("cnt after err", 32'(digit_cnt), 32'd3);
        $display("entry C rejected -> digit_cnt %0d", digit_cnt);
        capture("after err", e, 4'b0111);

        // 1..5 with saturation
        do_clear();
        check("cnt clear", 32'(digit_cnt), 32'd0);
        enter(4'd1); enter(4'd2); enter(4'd3); enter(4'd4); enter(4'd5);
        check("cnt sat", 32'(digit_cnt), 32'd4);
        e = {P_2, P_3, P_4, P_5};
        capture("2345", e, 4'b1111);

        // clear and valid together
        @(negedge clk);
        clear     = 1'b1;
        bcd_in    = 4'd7;
        bcd_valid = 1'b1;
        @(negedge clk);
        clear     = 1'b0;
        bcd_valid = 1'b0;
        check("clr+valid cnt", 32'(digit_cnt), 32'd0);
        check("clr+valid err", 32'(err), 32'd0);
        @(negedge clk);
        check("clr+valid err2", 32'(err), 32'd0);
        $display("clear with entry 7 -> digit_cnt %0d", digit_cnt);
        e = '1;
        capture("dark", e, 4'b0000);

        // Async reset during slot 2 drive
        enter(4'd1); enter(4'd2); enter(4'd3);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (an_n == 4'b1011) found = 1'b1;
        end
        check("slot2 drive found", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async an_n", 32'(an_n), 32'hF);
        check("async seg_n", 32'(seg_n), 32'(P_OFF));
        check("async cnt", 32'(digit_cnt), 32'd0);
        $display("async reset during slot 2");
        @(negedge clk);
        rst_n     = 1'b1;
        bcd_in    = 4'd7;
        bcd_valid = 1'b1;
        @(negedge clk);
        bcd_valid = 1'b0;
        check("post rst cyc1 an_n", 32'(an_n), 32'hF);
        @(negedge clk);
        check("post rst cyc2 an_n", 32'(an_n), 32'b1110);
        check("post rst cyc2 seg_n", 32'(seg_n), 32'(P_7));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
